tim_apb_master: RTL

APB4 initiator that turns single-word command requests into APB transfers towards the timer's register interface (TCR, TDR0/1, TCMP0/1, TIER, TISR, THCSR). It sits between a firmware-free control source (test sequencer, debug bridge or boot-time programmer) and the timer's APB slave port. It issues one transfer at a time and returns read data or error status on a response handshake. It enforces a wait-state timeout so a stuck responder cannot hang the requester.

---
 rtl/tim_apb_master_pkg.sv | 24 ++
 rtl/tim_apb_wait_timer.sv | 39 +++
 rtl/tim_apb_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tim_apb_master_pkg.sv
// Shared definitions for the timer APB initiator: FSM state encoding,
// timer register offsets and the default wait-state timeout.
package tim_apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } tim_apb_state_e;

  // Timer register map, also used by the timer's register block
  localparam logic [11:0] TIM_TCR_OFFS   = 12'h000;
  localparam logic [11:0] TIM_TDR0_OFFS  = 12'h004;
  localparam logic [11:0] TIM_TDR1_OFFS  = 12'h008;
  localparam logic [11:0] TIM_TCMP0_OFFS = 12'h00C;
  localparam logic [11:0] TIM_TCMP1_OFFS = 12'h010;
  localparam logic [11:0] TIM_TIER_OFFS  = 12'h014;
  localparam logic [11:0] TIM_TISR_OFFS  = 12'h018;
  localparam logic [11:0] TIM_THCSR_OFFS = 12'h01C;

  localparam int TIM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/tim_apb_wait_timer.sv
// Saturating ACCESS wait-state counter; expired_o is high once the count
// has reached TIMEOUT and stays high until the next clear.
module tim_apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit  = (cnt_q == CNT_W'(TIMEOUT));
  assign expired_o = at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tim_apb_master.sv
// APB4 initiator for the timer register block: one command in flight,
// registered APB and response outputs, wait-state timeout abort.
module tim_apb_master
  import tim_apb_master_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIM_TIMEOUT_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  // Valid/ready on both sides: a beat transfers on a rising edge where
  // valid and ready are both high; the source holds its payload until then.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic                tim_pslverr,
  input  logic [DATA_W-1:0]   tim_prdata,
  output logic [1:0]          dbg_state_o
);

  tim_apb_state_e state_q, state_d;

  logic                cmd_ready_q, rsp_valid_q;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [DATA_W/8-1:0] pstrb_q;

  logic accept, aligned;
  logic wt_clr, wt_en, wt_expired;

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign aligned = (cmd_addr[1:0] == 2'b00);

  tim_apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr_i    (wt_clr),
    .en_i     (wt_en),
    .expired_o(wt_expired)
  );

  always_comb begin
    state_d       = state_q;
    wt_clr        = 1'b0;
    wt_en         = 1'b0;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          if (!aligned) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d   = ST_SETUP;
            wt_clr    = 1'b1;
            rsp_err_d = 1'b0;
          end
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Completion takes priority over a timeout in the same cycle
        if (tim_pready) begin
          state_d       = ST_RESP;
          rsp_err_d     = tim_pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !tim_pslverr) ? tim_prdata : '0;
        end else if (wt_expired) begin
          state_d       = ST_RESP;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wt_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d       = ST_IDLE;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change only on edges
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == ST_IDLE);
      rsp_valid_q   <= (state_d == ST_RESP);
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      psel_q        <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_q     <= (state_d == ST_ACCESS);
      if (accept && aligned) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        pstrb_q  <= cmd_write ? cmd_strb : '0;
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;
  assign dbg_state_o = state_q;

endmodule
